// File: rtl/multi_channel_pdm_tuner_pkg.sv
// Shared defaults and ramp arithmetic for the multi-channel PDM heater tuner.
package multi_channel_pdm_tuner_pkg;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CODE_W    = 8;
  localparam int unsigned DEF_INIT_CODE = 0;
  localparam int unsigned DEF_RAMP_STEP = 1;
  localparam int unsigned DEF_RAMP_DIV  = 16;

  // Move cur toward target by at most step, never overshooting.
  function automatic int unsigned clamp_step(input int unsigned cur,
                                             input int unsigned target,
                                             input int unsigned step);
    int unsigned nxt;
    nxt = cur;
    if (cur < target)
      nxt = ((target - cur) > step) ? cur + step : target;
    else if (cur > target)
      nxt = ((cur - target) > step) ? cur - step : target;
    return nxt;
  endfunction

endpackage

// File: rtl/multi_channel_pdm_tuner_pdm_channel.sv
// One heater channel: target/current code, slew-limited ramp and first-order PDM.
module pdm_channel
  import multi_channel_pdm_tuner_pkg::*;
#(
  parameter int unsigned CODE_W    = DEF_CODE_W,
  parameter int unsigned INIT_CODE = DEF_INIT_CODE,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enable,
  input  logic              wr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              heater,
  output logic [CODE_W-1:0] cur_code,
  output logic              settled
);

  logic [CODE_W-1:0] target;
  logic [CODE_W-1:0] acc;
  logic [CODE_W:0]   sum;

  assign sum     = {1'b0, acc} + {1'b0, cur_code};
  assign settled = (cur_code == target);

  // The ramp reads the pre-write target, so a write on a tick edge takes effect next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= CODE_W'(INIT_CODE);
      cur_code <= CODE_W'(INIT_CODE);
      acc      <= '0;
      heater   <= 1'b0;
    end else begin
      if (wr)
        target <= wr_code;
      if (enable) begin
        heater <= sum[CODE_W];
        acc    <= sum[CODE_W-1:0];
        if (tick)
          cur_code <= CODE_W'(clamp_step(32'(cur_code), 32'(target), RAMP_STEP));
      end else begin
        heater <= 1'b0;
        acc    <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_pdm_tuner.sv
// NUM_CH-channel PDM heater tuner: shared prescaler, config decode and error flag.
module multi_channel_pdm_tuner
  import multi_channel_pdm_tuner_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CODE_W    = DEF_CODE_W,
  parameter int unsigned INIT_CODE = DEF_INIT_CODE,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
  parameter int unsigned RAMP_DIV  = DEF_RAMP_DIV
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CODE_W-1:0]                         cfg_code,
  input  logic [NUM_CH-1:0]                         enable,
  output logic [NUM_CH-1:0]                         heater,
  output logic [NUM_CH*CODE_W-1:0]                  cur_code,
  output logic [NUM_CH-1:0]                         settled,
  output logic                                      cfg_err
);

  localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  logic              accept;
  logic              in_range;
  logic [NUM_CH-1:0] wr;

  assign tick     = (prescaler == PRE_W'(RAMP_DIV - 1));
  assign accept   = cfg_valid & cfg_ready;
  assign in_range = (32'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (accept && !in_range)
        cfg_err <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c] = accept && in_range && (32'(cfg_ch) == 32'(c));

    pdm_channel #(
      .CODE_W   (CODE_W),
      .INIT_CODE(INIT_CODE),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .enable  (enable[c]),
      .wr      (wr[c]),
      .wr_code (cfg_code),
      .heater  (heater[c]),
      .cur_code(cur_code[c*CODE_W +: CODE_W]),
      .settled (settled[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_pdm_tuner.sv
// Self-checking bench: behavioural model compared every cycle plus literal expectations.
module tb_multi_channel_pdm_tuner;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int STEP = 3;
  localparam int DIV  = 5;

  logic           clk;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_code;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] heater;
  logic [NCH*W-1:0] cur_code;
  logic [NCH-1:0] settled;
  logic           cfg_err;

  multi_channel_pdm_tuner #(
    .NUM_CH   (NCH),
    .CODE_W   (W),
    .INIT_CODE(0),
    .RAMP_STEP(STEP),
    .RAMP_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_code (cfg_code),
    .enable   (enable),
    .heater   (heater),
    .cur_code (cur_code),
    .settled  (settled),
    .cfg_err  (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  bit cmp_on = 0;
  int cnt[NCH];

  int m_tgt[NCH];
  int m_cur[NCH];
  int m_acc[NCH];
  bit m_heat[NCH];
  bit m_err;
  bit m_ready;
  int m_edge;
  int s, d;
  bit tk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int dcur(input int c);
    return int'(cur_code[c*W +: W]);
  endfunction

  // Reference model: edges counted from reset release, ramp and PDM as plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_tgt[c] = 0; m_cur[c] = 0; m_acc[c] = 0; m_heat[c] = 0;
      end
      m_err = 0; m_ready = 0; m_edge = 0;
    end else begin
      tk = ((m_edge % DIV) == DIV - 1);
      for (int c = 0; c < NCH; c++) begin
        if (enable[c]) begin
          s = m_acc[c] + m_cur[c];
          m_heat[c] = (s >= (1 << W));
          m_acc[c]  = s % (1 << W);
          if (tk) begin
            d = m_tgt[c] - m_cur[c];
            if (d > 0) m_cur[c] += (d < STEP) ? d : STEP;
            else if (d < 0) m_cur[c] -= (-d < STEP) ? -d : STEP;
          end
        end else begin
          m_heat[c] = 0;
          m_acc[c]  = 0;
        end
      end
      if (cfg_valid && m_ready) begin
        if (int'(cfg_ch) < NCH) m_tgt[int'(cfg_ch)] = int'(cfg_code);
        else m_err = 1;
      end
      m_ready = 1;
      m_edge++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      #1;
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("heater%0d", c), int'(heater[c]), int'(m_heat[c]));
        check($sformatf("cur_code%0d", c), dcur(c), m_cur[c]);
        check($sformatf("settled%0d", c), int'(settled[c]), int'(m_cur[c] == m_tgt[c]));
      end
      check("cfg_err", int'(cfg_err), int'(m_err));
      check("cfg_ready", int'(cfg_ready), int'(m_ready));
    end
  end

  task automatic write(input int ch, input int code);
    cfg_valid = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_code  = code[W-1:0];
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_settled(input logic [NCH-1:0] mask, input string name);
    int n;
    n = 0;
    while (((settled & mask) != mask) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check(name, int'((settled & mask) == mask), 1);
  endtask

  task automatic count_pulses();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    repeat (1 << W) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) cnt[c] += int'(heater[c]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_code = '0; enable = '1;
    repeat (3) @(negedge clk);
    cmp_on = 1;
    check("rst_ready", int'(cfg_ready), 0);
    check("rst_heater", int'(heater), 0);
    check("rst_settled", int'(settled), 7);
    check("rst_err", int'(cfg_err), 0);
    check("rst_cur", int'(cur_code), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);

    write(1, 5);
    check("settled1_pending", int'(settled[1]), 0);
    repeat (3) @(negedge clk);
    check("cur1_first_tick", dcur(1), 3);
    write(1, 0);
    check("cur1_no_jump", dcur(1), 3);
    repeat (4) @(negedge clk);
    check("cur1_reversed", dcur(1), 0);
    check("settled1_back", int'(settled[1]), 1);

    write(0, 128);
    write(2, 255);
    wait_settled(3'b111, "settle_all");
    @(negedge clk);
    count_pulses();
    check("pulses_128", cnt[0], 128);
    check("pulses_0", cnt[1], 0);
    check("pulses_255", cnt[2], 255);

    write(3, 77);
    check("err_set", int'(cfg_err), 1);
    check("err_no_target_change", int'(settled), 7);
    write(2, 64);
    check("err_sticky", int'(cfg_err), 1);
    wait_settled(3'b100, "settle_64");
    @(negedge clk);
    enable[2] = 1'b0;
    @(negedge clk);
    check("heater2_off", int'(heater[2]), 0);
    write(2, 100);
    repeat (20) @(negedge clk);
    check("cur2_frozen", dcur(2), 64);
    check("settled2_low", int'(settled[2]), 0);
    write(2, 64);
    check("settled2_restored", int'(settled[2]), 1);
    enable[2] = 1'b1;
    count_pulses();
    check("pulses_64_reenable", cnt[2], 64);

    repeat (1500) begin
      cfg_valid = (($urandom % 3) == 0);
      cfg_ch    = 2'($urandom % 4);
      cfg_code  = W'($urandom);
      if (($urandom % 50) == 0) enable = NCH'($urandom);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    enable = '1;

    write(0, 200);
    write(1, 0);
    repeat (7) @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_code = 8'd9;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_cur", int'(cur_code), 0);
    check("async_heater", int'(heater), 0);
    check("async_settled", int'(settled), 7);
    check("async_err", int'(cfg_err), 0);
    check("async_ready", int'(cfg_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_after_release", int'(cfg_ready), 0);
    @(negedge clk);
    check("ready_high_again", int'(cfg_ready), 1);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("write_blocked_while_not_ready", int'(settled), 7);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
